// File: rtl/prog_loader.sv
// Boot-time program loader: assembles a big-endian byte stream into words,
// writes them to program memory, verifies a trailing checksum, then raises run.
module prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        run,
    output logic        err,
    output logic [10:0] words_loaded
);

    localparam logic [2:0] S_HDR   = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_CSUM  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] count_q, count_d;
    logic [31:0] sum_q, sum_d;
    logic [10:0] words_q, words_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        run_q, run_d;
    logic        err_q, err_d;

    logic        collecting;
    logic        take;
    logic        last_byte;
    logic [31:0] word_in;
    logic [10:0] words_inc;

    // Acceptance is derived from the state flop so it always agrees with in_ready_q.
    assign collecting = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign take       = in_valid && collecting;
    assign last_byte  = (bcnt_q == 2'd3);
    assign word_in    = {shift_q[23:0], in_data};
    assign words_inc  = words_q + 11'd1;

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        count_d     = count_q;
        sum_d       = sum_q;
        words_d     = words_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (take) begin
            shift_d = word_in;
            bcnt_d  = bcnt_q + 2'd1;
        end

        unique case (state_q)
            S_HDR: begin
                if (take && last_byte) begin
                    count_d = word_in;
                    if ((word_in == 32'd0) || (word_in > MAX_WORDS)) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take && last_byte) begin
                    state_d     = S_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = word_in;
                    mem_addr_d  = BASE_ADDR + {19'd0, words_q, 2'b00};
                end
            end
            S_WRITE: begin
                sum_d   = sum_q + mem_wdata_q;
                words_d = words_inc;
                if ({21'd0, words_inc} < count_q) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (take && last_byte) begin
                    if (word_in == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase

        // Status outputs are registered copies of the next state.
        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
        run_d      = (state_d == S_RUN);
        err_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            bcnt_q      <= 2'd0;
            shift_q     <= 32'd0;
            count_q     <= 32'd0;
            sum_q       <= 32'd0;
            words_q     <= 11'd0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
            run_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            words_q     <= words_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            run_q       <= run_d;
            err_q       <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign run          = run_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of `mips_cpu`. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words into the shared program/data memory at consecutive word addresses, checks a trailing 32-bit checksum, and only then raises `run`, which drives the CPU enable. While loading, the CPU is held idle and the loader owns the memory write port.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, byte address of the first word written; must be 4-byte aligned.
- `MAX_WORDS`, 1024, largest accepted word count N.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `mem_we`  out  1  one-cycle memory write strobe.
- `mem_addr`  out  32  byte address of the write.
- `mem_wdata`  out  32  word being written.
- `run`  out  1  load completed and checksum passed; drives CPU enable.
- `err`  out  1  load rejected; sticky.
- `words_loaded`  out  11  number of data words written so far.

## Operation
- Stream format, all fields big-endian (first byte is bits [31:24]):
  - 4-byte word count N.
  - N data words.
  - 4-byte checksum equal to the mod-2^32 sum of the N data words.
- A byte transfers only when `in_valid && in_ready` at a rising edge.
- States and transitions:
  - `HDR`: collect 4 count bytes. After the 4th byte, go to `ERROR` if N==0 or N>MAX_WORDS, else go to `DATA`.
  - `DATA`: collect 4 bytes into the word shift register. After the 4th byte, go to `WRITE`.
  - `WRITE`: one cycle. `mem_we`=1, `mem_addr`=BASE_ADDR+4*k, `mem_wdata`=word, where k is the 0-based word index.
    - Add the word to the running sum and increment `words_loaded`.
    - Next state is `DATA` if `words_loaded` (after increment) < N, else `CSUM`.
  - `CSUM`: collect 4 bytes. Go to `RUN` if they equal the running sum, else go to `ERROR`.
  - `RUN`: `run`=1, `in_ready`=0. Terminal until reset.
  - `ERROR`: `err`=1, `in_ready`=0. Terminal until reset.
- `in_ready`=1 in `HDR`, `DATA` and `CSUM`; 0 in `WRITE`, `RUN` and `ERROR`.
- Arithmetic and widths:
  - The byte counter within a word is 2 bits and wraps 3→0.
  - The checksum is a 32-bit sum; carries are discarded.
  - `mem_addr` is computed with 32-bit wrap, with no overflow check.
- `mem_addr` and `mem_wdata` are don't-care when `mem_we`=0. The bench checks them only on `mem_we`.
- Bytes presented while `in_ready`=0 are ignored; the upstream source must hold them.

## Timing
- Reset values:
  - state=`HDR`.
  - `in_ready`=1, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0.
  - `run`=0, `err`=0, `words_loaded`=0.
  - Byte counter, word count register and checksum sum all 0.
- Reset is synchronous and wins over every other event in the same cycle, including in `RUN` and `ERROR`. Reset mid-load discards partial words; words already written stay in memory.
- Byte-to-write latency: a word's 4th byte is accepted at edge t, and `mem_we` is high during cycle t+1.
  - `in_ready` is low during cycle t+1, so back-to-back words with continuous `in_valid` cost 5 cycles each.
- After the last checksum byte is accepted at edge t, `run` or `err` is high from cycle t+1 onward.
- Stalls (`in_valid`=0) in any collecting state hold all state; there is no timeout.
- Each output is registered (driven from a flop); no combinational path from `in_valid` or `in_data` to any output.

## Test plan
- Nominal load: N=2, words 32'h2008_0005, 32'h2009_0003, checksum 32'h4011_0008.
  - Required response: exactly two `mem_we` pulses at addresses 0x0 and 0x4 with those data, `words_loaded`=2, then `run`=1 and `err`=0.
- Bad checksum: same stream with checksum 32'h4011_0009.
  - Required response: both writes still occur, then `err`=1 and `run`=0 permanently. `in_ready`=0 afterward.
- Count bounds:
  - N=0 → `err`=1 after the 4th header byte, with no `mem_we`.
  - N=MAX_WORDS+1 → `err`=1.
  - N=MAX_WORDS with a correct checksum → `run`=1 and last write at BASE_ADDR+4*(MAX_WORDS-1).
- Handshake stress: N=3 with random `in_valid` gaps (0–5 cycles).
  - Required response: identical writes and checksum result to the gap-free case.
  - With `in_valid` held high through a `WRITE` cycle, the held byte is not consumed until `in_ready` returns.
- Checksum wrap: N=2, words 32'hFFFF_FFFF and 32'h0000_0002, checksum 32'h0000_0001.
  - Required response: `run`=1.
- Reset mid-operation: assert `reset` for one cycle after 6 bytes of an N=2 load, then send a full valid N=1 stream.
  - Required response: all outputs at reset values the cycle after reset. The single write goes to BASE_ADDR, then `run`=1.
